// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and Gray helpers used by both pointer domains.
// Depth defaults here; pointer logic carries one extra wrap bit beyond the RAM address.
package fifo_pkg;

    localparam int ADDRSIZE = 4;
    localparam int PTRW     = ADDRSIZE + 1;

    // Wide enough for any practical pointer; callers cast to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
// Zero latency, no flow control.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer, full/almost-full/level/overflow flags for the async FIFO; flags registered, one wclk of latency.
// Writes while full are refused (wen low, pointer held) and latch the sticky overflow flag.
module wptr_full #(
    parameter int ADDRSIZE     = fifo_pkg::ADDRSIZE,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   sync_rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wen,
    output logic [ADDRSIZE:0]   graycode_wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);
    import fifo_pkg::*;

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          afull_next;

    gray2bin #(.WIDTH(PW)) u_rptr_g2b (
        .gray (sync_rptr),
        .bin  (rbin_s)
    );

    assign wen        = winc & ~wfull;
    assign waddr      = wbin[ADDRSIZE-1:0];
    assign wbin_next  = wbin + PW'(wen);
    assign wgray_next = PW'(bin2gray(32'(wbin_next)));

    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted, rest equal.
    assign full_next  = (wgray_next == {~sync_rptr[ADDRSIZE:ADDRSIZE-1], sync_rptr[ADDRSIZE-2:0]});
    assign level_next = wbin_next - rbin_s;
    assign afull_next = (level_next >= PW'(AFULL_THRESH));

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin          <= '0;
            graycode_wptr <= '0;
            wfull         <= 1'b0;
            walmost_full  <= 1'b0;
            wlevel        <= '0;
            wovf          <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            graycode_wptr <= wgray_next;
            wfull         <= full_next;
            walmost_full  <= afull_next;
            wlevel        <= level_next;
            wovf          <= wovf | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// Scoreboard bench for wptr_full: expected post-edge outputs are queued as stimulus is driven
// and popped for comparison one time unit after each write-clock edge.
module tb_wptr_full;

    typedef struct packed {
        logic [3:0] waddr;
        logic [4:0] gray;
        logic       full;
        logic       afull;
        logic [4:0] level;
        logic       ovf;
    } obs_t;

    logic       wclk;
    logic       rst_n;
    logic       winc;
    logic [4:0] sync_rptr;
    logic [3:0] waddr;
    logic       wen;
    logic [4:0] graycode_wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;

    int   n_checks;
    int   n_errors;
    obs_t sb[$];

    logic [4:0] m_wbin;
    logic [4:0] m_level;
    logic       m_full;
    logic       m_afull;
    logic       m_ovf;

    wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
        .wclk          (wclk),
        .rst_n         (rst_n),
        .winc          (winc),
        .sync_rptr     (sync_rptr),
        .waddr         (waddr),
        .wen           (wen),
        .graycode_wptr (graycode_wptr),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .wlevel        (wlevel),
        .wovf          (wovf)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    function automatic obs_t observe();
        return {waddr, graycode_wptr, wfull, walmost_full, wlevel, wovf};
    endfunction

    task automatic model_reset();
        m_wbin  = '0;
        m_level = '0;
        m_full  = 1'b0;
        m_afull = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Apply one cycle of stimulus, push the model's post-edge prediction, and step past the edge.
    task automatic drive(input logic w, input logic [4:0] rp);
        logic [4:0] rb;
        logic [4:0] nb;
        logic       acc;
        obs_t       e;
        winc      = w;
        sync_rptr = rp;
        rb        = g2b(rp);
        acc       = w & ~m_full;
        nb        = m_wbin + {4'd0, acc};
        m_ovf     = m_ovf | (w & m_full);
        m_wbin    = nb;
        m_level   = nb - rb;
        m_full    = (m_level == 5'd16);
        m_afull   = (m_level >= 5'd12);
        e         = {nb[3:0], b2g(nb), m_full, m_afull, m_level, m_ovf};
        sb.push_back(e);
        @(posedge wclk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        winc  = 1'b0;
        sync_rptr = '0;
        model_reset();
        @(posedge wclk);
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        apply_reset();
        got = observe();
        n_checks++;
        if (got !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got %h required %h", got, obs_t'(0));
        end
        n_checks++;
        if (wen !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_wen: got %b required 0", wen);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        obs_t got;
        obs_t exp;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (waddr !== 4'(i)) begin
                n_errors++;
                $display("FAIL fill_waddr[%0d]: got %0d required %0d", i, waddr, i);
            end
            drive(1'b1, 5'd0);
            exp = sb.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL fill_step[%0d]: got %h required %h", i, got, exp);
            end
            n_checks++;
            if (walmost_full !== (i >= 11)) begin
                n_errors++;
                $display("FAIL fill_afull[%0d]: got %b required %b", i, walmost_full, (i >= 11));
            end
        end
        n_checks++;
        if (wfull !== 1'b1 || wlevel !== 5'd16) begin
            n_errors++;
            $display("FAIL fill_full: got full=%b level=%0d required full=1 level=16", wfull, wlevel);
        end
    endtask

    task automatic test_overflow();
        obs_t got;
        obs_t exp;
        winc = 1'b1;
        #1;
        n_checks++;
        if (wen !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_wen: got %b required 0", wen);
        end
        drive(1'b1, 5'd0);
        exp = sb.pop_front();
        got = observe();
        n_checks++;
        if (got !== exp || waddr !== 4'd0 || wovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_write: got %h required %h", got, exp);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0);
            exp = sb.pop_front();
            n_checks++;
            if (wovf !== 1'b1 || observe() !== exp) begin
                n_errors++;
                $display("FAIL ovf_sticky[%0d]: got %h required %h", i, observe(), exp);
            end
        end
    endtask

    task automatic test_read_release();
        obs_t exp;
        drive(1'b0, 5'b00110);
        exp = sb.pop_front();
        n_checks++;
        if (observe() !== exp || wfull !== 1'b0 || wlevel !== 5'd12) begin
            n_errors++;
            $display("FAIL read_release: got %h required %h", observe(), exp);
        end
    endtask

    task automatic test_simultaneous();
        obs_t exp;
        drive(1'b1, b2g(5'd5));
        exp = sb.pop_front();
        n_checks++;
        if (observe() !== exp || wlevel !== 5'd12 || walmost_full !== 1'b1) begin
            n_errors++;
            $display("FAIL simultaneous: got %h required %h", observe(), exp);
        end
    endtask

    task automatic test_wrap();
        obs_t       exp;
        logic [4:0] prev;
        int         wraps;
        wraps = 0;
        for (int i = 0; i < 40; i++) begin
            prev = graycode_wptr;
            drive(1'b1, b2g(m_wbin - 5'd8));
            exp = sb.pop_front();
            n_checks++;
            if (observe() !== exp || $countones(prev ^ graycode_wptr) != 1) begin
                n_errors++;
                $display("FAIL wrap_step[%0d]: got %h required %h prev_gray %h", i, observe(), exp, prev);
            end
            if (prev == 5'b10000 && graycode_wptr == 5'b00000) wraps++;
        end
        n_checks++;
        if (wraps != 1) begin
            n_errors++;
            $display("FAIL wrap_count: got %0d required 1", wraps);
        end
    endtask

    task automatic test_async_reset();
        obs_t exp;
        apply_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 5'd0);
            exp = sb.pop_front();
            n_checks++;
            if (observe() !== exp) begin
                n_errors++;
                $display("FAIL burst_step[%0d]: got %h required %h", i, observe(), exp);
            end
        end
        n_checks++;
        if (wlevel !== 5'd7) begin
            n_errors++;
            $display("FAIL burst_level: got %0d required 7", wlevel);
        end
        winc = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (observe() !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got %h required %h", observe(), obs_t'(0));
        end
        winc = 1'b0;
        @(posedge wclk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 5'd0);
        exp = sb.pop_front();
        n_checks++;
        if (observe() !== exp) begin
            n_errors++;
            $display("FAIL post_reset_write: got %h required %h", observe(), exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        winc      = 1'b0;
        sync_rptr = '0;
        model_reset();
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and flag generator for the asynchronous FIFO, running entirely in the write clock domain. It consumes the two-flop-synchronized Gray read pointer and produces the binary RAM write address, the Gray write pointer for the write-to-read synchronizer, and registered full, almost-full, fill-level and sticky overflow indications. It sits between the write-side user logic and the dual-port RAM, directly downstream of the read-pointer synchronizer.

## Interface
- ADDRSIZE, 4, RAM address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
- AFULL_THRESH, 12, fill level at or above which walmost_full asserts; legal range 1..2**ADDRSIZE.
- wclk  input  1  write clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- winc  input  1  write request; accepted only when wfull is low.
- sync_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronized into wclk.
- waddr  output  ADDRSIZE  RAM write address (low bits of binary write pointer).
- wen  output  1  RAM write enable = winc & ~wfull (combinational).
- graycode_wptr  output  ADDRSIZE+1  registered Gray write pointer, to the write-to-read synchronizer.
- wfull  output  1  registered full flag.
- walmost_full  output  1  registered, level >= AFULL_THRESH.
- wlevel  output  ADDRSIZE+1  registered fill level, 0..2**ADDRSIZE.
- wovf  output  1  sticky overflow: set when winc is high while wfull is high.

## Operation
- Reset (rst_n low, asynchronous): wbin, graycode_wptr, wlevel = 0; wfull, walmost_full, wovf = 0. Release takes effect on the next wclk edge.
- wbin_next = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1); wraps from all-ones to 0.
- wgray_next = (wbin_next >> 1) ^ wbin_next; graycode_wptr is updated only from wgray_next and never glitches through non-adjacent codes.
- Full: wfull <= (wgray_next == {~sync_rptr[ADDRSIZE:ADDRSIZE-1], sync_rptr[ADDRSIZE-2:0]}).
- Level: rbin_s = Gray-to-binary(sync_rptr); wlevel <= wbin_next - rbin_s (mod 2**(ADDRSIZE+1)); value 2**ADDRSIZE exactly when wfull is set.
- walmost_full <= (wbin_next - rbin_s) >= AFULL_THRESH.
- Write while full: pointer unchanged, wen low, wovf <= 1. wovf stays set until reset.
- sync_rptr advancing in the same cycle as an accepted write: both are reflected in that cycle's wfull, wlevel and walmost_full. There is no priority conflict.
- Flags are pessimistic. sync_rptr lags the true read pointer by the synchronizer latency, so wfull may hold after reads and wlevel may overstate the fill level. Neither may ever understate it.

## Timing
- Accepted write at edge N: waddr shows the written slot before edge N. waddr, graycode_wptr, wfull, wlevel and walmost_full show the new values after edge N (1-cycle latency).
- wen and waddr are valid in the same cycle as winc. The RAM captures data at edge N.
- A change on sync_rptr is reflected in the flags one edge later.
- Reset asserted mid-burst clears all state immediately. A write presented in the cycle of reset assertion is lost.

## Structure
- Shared package fifo_pkg: ADDRSIZE default, pointer-width constant PTRW = ADDRSIZE+1, and a bin2gray function.
- One sub-module: gray2bin (parameterized width, combinational XOR prefix), reusable by the read-side empty logic.
- The full comparison and level arithmetic stay in the top module.

## Test plan
- Reset, then 16 back-to-back writes with sync_rptr = 0: waddr runs 0..15, wfull rises after the 16th edge, wlevel = 16, walmost_full rises after the 12th write.
- 17th write while full: wen low, waddr stays 0, wovf = 1 and stays 1 across later idle cycles.
- Full, then sync_rptr stepped to Gray(4) = 5'b00110: wfull clears one edge later, wlevel = 12.
- Pointer wrap: drive 40 writes, interleaving sync_rptr updates to keep the FIFO non-full. graycode_wptr changes by exactly one bit per accepted write, and wbin wraps 31 -> 0.
- Simultaneous write and sync_rptr advance at wlevel = 12: wlevel stays 12 and walmost_full stays 1.
- Drop rst_n asynchronously mid-burst at wlevel = 7: all outputs go to 0 before the next wclk edge.
